// File: rtl/video_timing_probe.sv
// video_timing_probe: sink-side monitor of a pixel-clocked video stream.
// Measures line/frame timing, field order, lock and signal presence.
module video_timing_probe #(
  parameter int HCNT_W       = 12,
  parameter int VCNT_W       = 11,
  parameter int TIMEOUT_CLKS = 4194304
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ce_pix,
  input  logic              HSync,
  input  logic              VSync,
  input  logic              HBlank,
  input  logic              VBlank,
  output logic [HCNT_W-1:0] h_total,
  output logic [HCNT_W-1:0] h_active,
  output logic [HCNT_W-1:0] h_sync_w,
  output logic [VCNT_W-1:0] v_total,
  output logic [VCNT_W-1:0] v_active,
  output logic [VCNT_W-1:0] v_sync_w,
  output logic              field,
  output logic              interlaced,
  output logic              frame_valid,
  output logic              locked,
  output logic              present,
  output logic              overflow
);
  localparam int TO_W = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [HCNT_W-1:0] H_MAX = '1;
  localparam logic [VCNT_W-1:0] V_MAX = '1;
  localparam logic [TO_W-1:0] TO_END = TO_W'(TIMEOUT_CLKS);
  logic hs_q, vs_q, armed, ovf, ovf_n, line_start, hs_fall, frame_start, f;
  logic [HCNT_W-1:0] h_cnt, hs_cnt, de_cnt, line_total, line_active, line_sync;
  logic [HCNT_W-1:0] h_inc, h_cnt_n, hs_base, hs_cnt_n, de_base, de_cnt_n, lt_n, la_n, ls_n, q_lt;
  logic [VCNT_W-1:0] v_cnt, a_lines, vs_cnt, v_cnt_n, a_lines_n, vs_cnt_n;
  logic [TO_W-1:0] to_cnt;
  // Next-state values with the line start of this pixel already applied, so a
  // coincident frame start reports the line that just ended.
  always_comb begin
    line_start  = ce_pix & HSync & ~hs_q;
    hs_fall     = ce_pix & ~HSync & hs_q;
    frame_start = ce_pix & VSync & ~vs_q;
    h_inc       = (h_cnt == H_MAX) ? H_MAX : h_cnt + 1'b1;
    h_cnt_n     = line_start ? '0 : h_inc;
    hs_base     = line_start ? '0 : hs_cnt;
    hs_cnt_n    = (HSync && hs_base != H_MAX) ? hs_base + 1'b1 : hs_base;
    de_base     = line_start ? '0 : de_cnt;
    de_cnt_n    = (!(HBlank || VBlank) && de_base != H_MAX) ? de_base + 1'b1 : de_base;
    lt_n        = line_start ? h_inc : line_total;
    la_n        = (line_start && de_cnt != '0) ? de_cnt : line_active;
    ls_n        = hs_fall ? hs_cnt : line_sync;
    v_cnt_n     = (line_start && v_cnt != V_MAX) ? v_cnt + 1'b1 : v_cnt;
    a_lines_n   = (line_start && de_cnt != '0 && a_lines != V_MAX) ? a_lines + 1'b1 : a_lines;
    vs_cnt_n    = (line_start && VSync && vs_cnt != V_MAX) ? vs_cnt + 1'b1 : vs_cnt;
    ovf_n       = ovf | (h_cnt == H_MAX) | (HSync & (hs_base == H_MAX))
                | (~(HBlank | VBlank) & (de_base == H_MAX))
                | (line_start & ((v_cnt == V_MAX) | ((de_cnt != '0) & (a_lines == V_MAX))
                | (VSync & (vs_cnt == V_MAX))));
    q_lt        = lt_n >> 2;
    f           = (h_cnt_n >= q_lt) && (h_cnt_n < (lt_n >> 1) + q_lt);
  end
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      armed       <= 1'b0;
      ovf         <= 1'b0;
      h_cnt       <= '0;
      hs_cnt      <= '0;
      de_cnt      <= '0;
      line_total  <= '0;
      line_active <= '0;
      line_sync   <= '0;
      v_cnt       <= '0;
      a_lines     <= '0;
      vs_cnt      <= '0;
      to_cnt      <= '0;
      h_total     <= '0;
      h_active    <= '0;
      h_sync_w    <= '0;
      v_total     <= '0;
      v_active    <= '0;
      v_sync_w    <= '0;
      field       <= 1'b0;
      interlaced  <= 1'b0;
      frame_valid <= 1'b0;
      locked      <= 1'b0;
      present     <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      to_cnt      <= frame_start ? '0 : (to_cnt == TO_END) ? to_cnt : to_cnt + 1'b1;
      if (ce_pix) begin
        hs_q        <= HSync;
        vs_q        <= VSync;
        h_cnt       <= h_cnt_n;
        hs_cnt      <= hs_cnt_n;
        de_cnt      <= de_cnt_n;
        line_total  <= lt_n;
        line_active <= la_n;
        line_sync   <= ls_n;
        v_cnt       <= frame_start ? '0 : v_cnt_n;
        a_lines     <= frame_start ? '0 : a_lines_n;
        vs_cnt      <= frame_start ? VCNT_W'(line_start) : vs_cnt_n;
        ovf         <= ~frame_start & ovf_n;
      end
      if (frame_start) begin
        armed <= 1'b1;
        if (armed) begin
          h_total     <= lt_n;
          h_active    <= la_n;
          h_sync_w    <= ls_n;
          v_total     <= v_cnt_n;
          v_active    <= a_lines_n;
          v_sync_w    <= vs_cnt;
          field       <= f;
          interlaced  <= f != field;
          overflow    <= ovf_n;
          locked      <= (lt_n == h_total) && (v_cnt_n == v_total);
          present     <= 1'b1;
          frame_valid <= 1'b1;
        end
      end else if (to_cnt == TO_END) begin
        armed   <= 1'b0;
        present <= 1'b0;
        locked  <= 1'b0;
      end
    end
  end
endmodule

// File: doc/video_timing_probe.md
Name: video_timing_probe

Overview:
- Sink-side monitor for the suite's pixel-clocked video stream (ce_pix, HSync, VSync, HBlank, VBlank), i.e. the consumer of what the video generator emits.
- Measures horizontal and vertical timing per frame and detects interlaced field order.
- Reports lock/presence so the core can self-check generated modes and show measured timing on the OSD/status.
- Sits in the clk_sys domain beside the generator.

Parameters:
- HCNT_W, 12, width of horizontal pixel counters and outputs.
- VCNT_W, 11, width of line counters and outputs.
- TIMEOUT_CLKS, 4194304, clk_sys cycles without a frame start before signal is declared absent.

Ports:
- clk_sys  in  1  system/video clock.
- reset_n  in  1  asynchronous reset, active-low.
- ce_pix  in  1  pixel enable; all video inputs sampled only when high.
- HSync  in  1  horizontal sync, active-high.
- VSync  in  1  vertical sync, active-high.
- HBlank  in  1  horizontal blank.
- VBlank  in  1  vertical blank.
- h_total  out  HCNT_W  pixels per line.
- h_active  out  HCNT_W  active (DE) pixels per line.
- h_sync_w  out  HCNT_W  HSync width in pixels.
- v_total  out  VCNT_W  lines per frame/field.
- v_active  out  VCNT_W  lines containing ≥1 DE pixel.
- v_sync_w  out  VCNT_W  line starts seen while VSync high.
- field  out  1  field of last reported frame (1 = VSync rose mid-line).
- interlaced  out  1  last two fields differed.
- frame_valid  out  1  one-clk_sys pulse when the output set updates.
- locked  out  1  two consecutive frames had equal h_total and v_total.
- present  out  1  frame starts arriving within TIMEOUT_CLKS.
- overflow  out  1  any counter saturated in the last reported frame.

Behaviour:
- Reset (async, reset_n=0): all outputs 0; all counters and edge registers 0; first-frame flag cleared.
- DE = ~(HBlank|VBlank).
- Edge detect uses sync copies registered only on ce_pix. With ce_pix low nothing changes except the timeout counter, so results are independent of the ce_pix rate.
- Line start: ce_pix with HSync=1 while previous HSync=0.
- h_cnt: cleared to 0 on line start, else +1 per ce_pix.
- At a line start, latch line_total = h_cnt+1.
- hs_cnt counts ce_pix with HSync=1 since line start; latched to line_sync at HSync falling edge.
- de_cnt counts DE pixels in the line. At line start, if de_cnt≠0: line_active = de_cnt and a_lines += 1. de_cnt then clears.
- All horizontal counters saturate at all-ones and set an ovf flag.
- Frame start: ce_pix with VSync=1 while previous VSync=0.
- v_cnt increments per line start and saturates (sets ovf).
- vs_cnt counts line starts while VSync=1.
- Field classification at frame start: f = 1 if line_total/4 ≤ h_cnt < 3·line_total/4, else 0. Use shifts; 3·line_total/4 = line_total/2 + line_total/4.
- Frame start and line start on the same ce_pix: the line start is processed first, so that line counts toward the ending frame.
- At each frame start after the first:
  - Update all outputs in the same clk_sys cycle: h_total=line_total, h_active=line_active, h_sync_w=line_sync, v_total=v_cnt, v_active=a_lines, v_sync_w=vs_cnt, field=f, interlaced=(f≠field), overflow=ovf.
  - Pulse frame_valid for one clk_sys, on the cycle after the frame-start ce_pix.
  - locked = (line_total==h_total_prev && v_cnt==v_total_prev), where prev are the previous reported values.
- First frame start after reset: arms only. It clears frame counters; no frame_valid, no output update.
- Frame counters (v_cnt, a_lines, vs_cnt, ovf) clear on every frame start. vs_cnt counts from the frame-start line.
- Timeout: a clk_sys counter, reset on each frame start.
  - On reaching TIMEOUT_CLKS: present=0, locked=0, first-frame flag cleared (re-arm). Measurement outputs hold their last values.
  - present=1 on the first reported frame.
- Interlace: v_total alternates (e.g. 262/263). locked therefore stays 0 when totals alternate; interlaced is the indicator.
- Reset mid-frame: all state clears immediately. The partial frame is never reported.

Test Plan:
- Progressive 320x240: line 426 px (DE 320, HSync 32), frame 262 lines (240 active, VSync 3 lines), ce_pix every 4 clk. Required: 1st VSync edge gives no pulse; 2nd gives frame_valid with h_total=426, h_active=320, h_sync_w=32, v_total=262, v_active=240, v_sync_w=3, field=0, interlaced=0, locked=0; 3rd gives locked=1, present=1.
- Same stream with ce_pix=1 every clk -> identical values; frame_valid exactly one clk_sys wide.
- 480i: alternating 262/263-line fields, VSync rising at h_cnt=213 on odd fields -> field toggles 0/1 each report, interlaced=1 from the 2nd report, locked=0.
- Stop VSync after lock for TIMEOUT_CLKS+10 clk -> present=0, locked=0, measurements held. Resume -> one arming frame, then reports resume.
- Drive HSync only every 5000 px (HCNT_W=12) -> h_total=4095, overflow=1 in that report. Next normal frame -> overflow=0.
- Assert reset_n=0 for 3 clk mid-frame after lock -> all outputs 0 asynchronously. After release, the first report comes on the 2nd VSync edge.
